// File: rtl/sram_fill_pkg.sv
// sram_fill_pkg: shared types and helpers for the SRAM fill sequencer.
//   state_t    : controller states (IDLE, FILL, DONE)
//   LANES, AW  : beat width in lanes, SRAM address width
//   wrap_addr  : reduce a lane address sum modulo the SRAM depth
package sram_fill_pkg;

   localparam int N_ENTRIES_DEF = 10240;
   localparam int LANES         = 8;
   localparam int AW            = $clog2(N_ENTRIES_DEF);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      FILL = 2'd1,
      DONE = 2'd2
   } state_t;

   // Compare-and-subtract modulo. Live lanes always fall below 2*n_entries.
   // Dropped lanes past len on the final beat can overshoot that by a few
   // entries, so a second subtract keeps even their (masked) addresses legal.
   function automatic logic [AW-1:0] wrap_addr(input logic [AW:0] sum,
                                               input logic [AW:0] n_entries);
      logic [AW:0] s;
      s = sum;
      if (s >= n_entries) s = s - n_entries;
      if (s >= n_entries) s = s - n_entries;
      return AW'(s);
   endfunction

endpackage

// File: rtl/sram_fill_lane_gen.sv
// sram_fill_lane_gen: combinational per-lane address and write-enable
// generation for one beat.
//   base   in  AW     command start address
//   offset in  AW+1   byte offset of this beat within the command
//   len    in  AW+1   command byte count
//   addr   out LANES*AW  lane k address = (base+offset+k) mod N_ENTRIES
//   we     out LANES     lane k enabled while offset+k < len
module sram_fill_lane_gen
   import sram_fill_pkg::*;
#(
   parameter int N_ENTRIES = N_ENTRIES_DEF
) (
   input  logic [AW-1:0]       base,
   input  logic [AW:0]         offset,
   input  logic [AW:0]         len,
   output logic [LANES*AW-1:0] addr,
   output logic [LANES-1:0]    we
);

   localparam logic [AW:0] N_W = (AW+1)'(N_ENTRIES);

   for (genvar k = 0; k < LANES; k++) begin : g_lane
      logic [AW:0] pos;
      assign pos                = offset + (AW+1)'(k);
      assign addr[k*AW +: AW]   = wrap_addr({1'b0, base} + pos, N_W);
      assign we[k]              = (pos < len);
   end

endmodule

// File: rtl/sram_fill_ctrl.sv
// sram_fill_ctrl: write sequencer for the 8-lane byte scratch SRAM.
// Takes one fill command (base, len), then turns each accepted 64-bit beat
// into one registered 8-lane SRAM write, masking bytes past len and wrapping
// addresses modulo N_ENTRIES.
//   clk, reset_n          clock, async active-low reset
//   cmd_valid/cmd_ready   command handshake (ready only in IDLE)
//   cmd_base, cmd_len     start address, byte count (0..N_ENTRIES)
//   in_valid/in_ready     beat handshake (ready only in FILL)
//   in_data               lane k = in_data[k*DATA_LEN +: DATA_LEN]
//   sram_en/we/addr/data  registered SRAM write port
//   done                  one-cycle pulse alongside the final write
//   err                   one-cycle pulse on a rejected command
// Build option: SRAM_FILL_BOUNDS_CHECK_EN rejects commands with
// base+len > N_ENTRIES; without it err is tied low and addresses wrap.
//
// state | meaning
// IDLE  | waiting for a command; cmd_ready high
// FILL  | accepting beats; in_ready high
// DONE  | final write on the SRAM port; done high for one cycle
module sram_fill_ctrl
   import sram_fill_pkg::*;
#(
   parameter int DATA_LEN  = 8,
   parameter int N_ENTRIES = N_ENTRIES_DEF
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic                      cmd_valid,
   output logic                      cmd_ready,
   input  logic [AW-1:0]             cmd_base,
   input  logic [AW:0]               cmd_len,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [LANES*DATA_LEN-1:0] in_data,
   output logic                      sram_en,
   output logic [LANES-1:0]          sram_we,
   output logic [LANES*AW-1:0]       sram_addr,
   output logic [LANES*DATA_LEN-1:0] sram_data,
   output logic                      done,
   output logic                      err
);

   localparam logic [AW:0] LANES_W = (AW+1)'(LANES);

   state_t               state_q, state_d;
   logic [AW-1:0]        base_q;
   logic [AW:0]          len_q;
   logic [AW:0]          offset_q;
   logic [AW:0]          remaining_q;
   logic                 cmd_acc;
   logic                 beat;
   logic                 cmd_bad;
   logic [LANES*AW-1:0]  lane_addr;
   logic [LANES-1:0]     lane_we;

   assign cmd_ready = (state_q == IDLE);
   assign in_ready  = (state_q == FILL);
   assign cmd_acc   = cmd_valid && cmd_ready;
   assign beat      = in_valid && in_ready;
   assign done      = (state_q == DONE);

`ifdef SRAM_FILL_BOUNDS_CHECK_EN
   logic [AW+1:0] cmd_end;
   logic          err_q;

   assign cmd_end = {2'b00, cmd_base} + {1'b0, cmd_len};
   assign cmd_bad = (cmd_end > (AW+2)'(N_ENTRIES));

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) err_q <= 1'b0;
      else          err_q <= cmd_acc && cmd_bad;
   end

   assign err = err_q;
`else
   assign cmd_bad = 1'b0;
   assign err     = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (cmd_acc) begin
               if (cmd_bad)           state_d = IDLE;
               else if (cmd_len == '0) state_d = DONE;
               else                   state_d = FILL;
            end
         end
         FILL: begin
            // remaining counts down by a beat; the beat that reaches the
            // terminal count is the last one
            if (beat && (remaining_q <= LANES_W)) state_d = DONE;
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state_q <= IDLE;
      else          state_q <= state_d;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         base_q      <= '0;
         len_q       <= '0;
         offset_q    <= '0;
         remaining_q <= '0;
      end else if (cmd_acc) begin
         base_q      <= cmd_base;
         len_q       <= cmd_len;
         offset_q    <= '0;
         remaining_q <= cmd_len;
      end else if (beat) begin
         offset_q    <= offset_q + LANES_W;
         remaining_q <= (remaining_q > LANES_W) ? (remaining_q - LANES_W) : '0;
      end
   end

   sram_fill_lane_gen #(
      .N_ENTRIES (N_ENTRIES)
   ) u_lane_gen (
      .base   (base_q),
      .offset (offset_q),
      .len    (len_q),
      .addr   (lane_addr),
      .we     (lane_we)
   );

   // Address and data hold between beats; only en/we return to zero.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sram_en   <= 1'b0;
         sram_we   <= '0;
         sram_addr <= '0;
         sram_data <= '0;
      end else begin
         sram_en <= beat;
         sram_we <= beat ? lane_we : '0;
         if (beat) begin
            sram_addr <= lane_addr;
            sram_data <= in_data;
         end
      end
   end

endmodule

// File: tb/tb_sram_fill_ctrl.sv
// tb_sram_fill_ctrl: self-checking bench for sram_fill_ctrl. A behavioural
// SRAM captures the DUT's writes; the expected image and per-beat write
// contents come from modulo arithmetic on (base, len, beat index).
module tb_sram_fill_ctrl;

   localparam int N  = 10240;
   localparam int AW = 14;
   localparam int L  = 8;
   localparam int DL = 8;

   logic              clk = 1'b0;
   logic              reset_n = 1'b0;
   logic              cmd_valid = 1'b0;
   logic              cmd_ready;
   logic [AW-1:0]     cmd_base = '0;
   logic [AW:0]       cmd_len = '0;
   logic              in_valid = 1'b0;
   logic              in_ready;
   logic [L*DL-1:0]   in_data = '0;
   logic              sram_en;
   logic [L-1:0]      sram_we;
   logic [L*AW-1:0]   sram_addr;
   logic [L*DL-1:0]   sram_data;
   logic              done;
   logic              err;

   logic [7:0]        mem     [N];
   logic [7:0]        exp_mem [N];
   logic              preload = 1'b1;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   sram_fill_ctrl dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_base  (cmd_base),
      .cmd_len   (cmd_len),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .sram_en   (sram_en),
      .sram_we   (sram_we),
      .sram_addr (sram_addr),
      .sram_data (sram_data),
      .done      (done),
      .err       (err)
   );

   always @(posedge clk) begin
      if (preload) begin
         for (int i = 0; i < N; i++) mem[i] <= 8'(i*37 + 5);
      end else if (sram_en) begin
         for (int k = 0; k < L; k++)
            if (sram_we[k]) mem[sram_addr[k*AW +: AW]] <= sram_data[k*DL +: DL];
      end
   end

   function automatic int wrapi(input int a);
      return ((a % N) + N) % N;
   endfunction

   task automatic send_cmd(input int b, input int l);
      int n = 0;
      @(negedge clk);
      cmd_valid = 1'b1;
      cmd_base  = AW'(b);
      cmd_len   = (AW+1)'(l);
      while (!cmd_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (cmd_ready !== 1'b1) begin
         errors++;
         $display("FAIL cmd_timeout cmd_ready=%0b expected 1", cmd_ready);
      end
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
   endtask

   // mode 0: in_valid every cycle, 1: every other cycle, 2: random gaps
   task automatic stream(input int b, input int l, input int mode, input bit fixed);
      int nbeats = (l + L - 1) / L;
      int beat_i = 0;
      int cyc    = 0;
      bit pend   = 1'b0;
      bit last   = 1'b0;
      bit want;
      int off;
      logic [L*AW-1:0] e_addr = '0;
      logic [L-1:0]    e_we   = '0;
      logic [L*DL-1:0] e_data = '0;
      while ((beat_i < nbeats || pend) && cyc < 400) begin
         @(negedge clk);
         checks++;
         if (pend) begin
            if (sram_en !== 1'b1 || sram_we !== e_we || sram_addr !== e_addr || sram_data !== e_data) begin
               errors++;
               $display("FAIL beat_write en=%0b we=%h addr=%h data=%h expected en=1 we=%h addr=%h data=%h",
                        sram_en, sram_we, sram_addr, sram_data, e_we, e_addr, e_data);
            end
         end else if (sram_en !== 1'b0 || sram_we !== '0) begin
            errors++;
            $display("FAIL idle_cycle en=%0b we=%h expected en=0 we=00", sram_en, sram_we);
         end
         checks++;
         if (done !== (pend && last)) begin
            errors++;
            $display("FAIL done_timing done=%0b expected %0b", done, pend && last);
         end
         want = (beat_i < nbeats) &&
                (mode == 0 || (mode == 1 && cyc % 2 == 0) ||
                 (mode == 2 && $urandom_range(0, 1) == 1));
         in_valid = want;
         for (int k = 0; k < L; k++)
            in_data[k*DL +: DL] = fixed ? 8'(beat_i*L + k) : 8'($urandom);
         pend = want && in_ready;
         if (pend) begin
            off  = beat_i * L;
            last = (off + L >= l);
            for (int k = 0; k < L; k++) begin
               e_addr[k*AW +: AW] = AW'(wrapi(b + off + k));
               e_we[k]            = (off + k < l);
               e_data[k*DL +: DL] = in_data[k*DL +: DL];
               if (off + k < l) exp_mem[wrapi(b + off + k)] = in_data[k*DL +: DL];
            end
            beat_i++;
         end
         cyc++;
      end
      in_valid = 1'b0;
      checks++;
      if (cyc >= 400) begin
         errors++;
         $display("FAIL stream_timeout beats=%0d expected %0d", beat_i, nbeats);
      end
   endtask

   task automatic run_fill(input int b, input int l, input int mode, input bit fixed);
      send_cmd(b, l);
`ifdef SRAM_FILL_BOUNDS_CHECK_EN
      if (b + l > N) begin
         @(negedge clk);
         checks++;
         if (err !== 1'b1 || in_ready !== 1'b0 || sram_en !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reject err=%0b in_ready=%0b en=%0b done=%0b expected 1 0 0 0",
                     err, in_ready, sram_en, done);
         end
         @(negedge clk);
         checks++;
         if (err !== 1'b0 || cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL reject_end err=%0b cmd_ready=%0b expected 0 1", err, cmd_ready);
         end
         return;
      end
`endif
      if (l == 0) begin
         @(negedge clk);
         checks++;
         if (done !== 1'b1 || sram_en !== 1'b0 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL len_zero done=%0b en=%0b in_ready=%0b expected 1 0 0",
                     done, sram_en, in_ready);
         end
      end else begin
         stream(b, l, mode, fixed);
      end
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || cmd_ready !== 1'b1 || in_ready !== 1'b0 || sram_en !== 1'b0 || err !== 1'b0) begin
         errors++;
         $display("FAIL after_cmd done=%0b cmd_ready=%0b in_ready=%0b en=%0b err=%0b expected 0 1 0 0 0",
                  done, cmd_ready, in_ready, sram_en, err);
      end
      for (int i = -4; i < l + 12; i++) begin
         checks++;
         if (mem[wrapi(b + i)] !== exp_mem[wrapi(b + i)]) begin
            errors++;
            $display("FAIL readback addr=%0d got %h expected %h",
                     wrapi(b + i), mem[wrapi(b + i)], exp_mem[wrapi(b + i)]);
         end
      end
   endtask

   task automatic test_reset();
      repeat (2) @(negedge clk);
      checks++;
      if (sram_en !== 1'b0 || sram_we !== '0 || sram_addr !== '0 || sram_data !== '0 ||
          done !== 1'b0 || err !== 1'b0 || in_ready !== 1'b0 || cmd_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_state en=%0b we=%h addr=%h data=%h done=%0b err=%0b in_ready=%0b cmd_ready=%0b",
                  sram_en, sram_we, sram_addr, sram_data, done, err, in_ready, cmd_ready);
      end
      preload = 1'b0;
      reset_n = 1'b1;
      @(negedge clk);
      checks++;
      if (cmd_ready !== 1'b1 || sram_en !== 1'b0) begin
         errors++;
         $display("FAIL post_reset cmd_ready=%0b en=%0b expected 1 0", cmd_ready, sram_en);
      end
   endtask

   task automatic test_full_fill();
      run_fill(0, 16, 0, 1'b1);
      for (int i = 0; i < 16; i++) begin
         checks++;
         if (mem[i] !== 8'(i)) begin
            errors++;
            $display("FAIL full_fill addr=%0d got %h expected %h", i, mem[i], 8'(i));
         end
      end
   endtask

   task automatic test_partial();
      run_fill(100, 11, 0, 1'b1);
      checks++;
      if (mem[110] !== 8'd10 || mem[111] !== 8'(111*37 + 5)) begin
         errors++;
         $display("FAIL partial_last mem110=%h mem111=%h expected 0a %h",
                  mem[110], mem[111], 8'(111*37 + 5));
      end
   endtask

   task automatic test_wrap();
      run_fill(10236, 8, 0, 1'b1);
      checks++;
`ifdef SRAM_FILL_BOUNDS_CHECK_EN
      if (mem[10236] !== 8'(10236*37 + 5)) begin
         errors++;
         $display("FAIL wrap_rejected mem10236=%h expected %h", mem[10236], 8'(10236*37 + 5));
      end
`else
      if (mem[10236] !== 8'd0 || mem[10239] !== 8'd3 || mem[0] !== 8'd4 || mem[3] !== 8'd7) begin
         errors++;
         $display("FAIL wrap_addr mem10236=%h mem10239=%h mem0=%h mem3=%h expected 00 03 04 07",
                  mem[10236], mem[10239], mem[0], mem[3]);
      end
`endif
   endtask

   task automatic test_backpressure();
      run_fill(500, 40, 1, 1'b0);
      run_fill(700, 29, 2, 1'b0);
   endtask

   task automatic test_len_zero();
      run_fill(77, 0, 0, 1'b0);
   endtask

   task automatic test_reset_mid_fill();
      send_cmd(2000, 32);
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = {$urandom, $urandom};
      @(posedge clk);
      #1;
      checks++;
      if (sram_en !== 1'b1 || sram_we !== 8'hFF) begin
         errors++;
         $display("FAIL midfill_beat1 en=%0b we=%h expected 1 ff", sram_en, sram_we);
      end
      #1;
      reset_n = 1'b0;
      #1;
      checks++;
      if (sram_en !== 1'b0 || sram_we !== '0 || in_ready !== 1'b0) begin
         errors++;
         $display("FAIL midfill_async en=%0b we=%h in_ready=%0b expected 0 00 0",
                  sram_en, sram_we, in_ready);
      end
      in_valid = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      checks++;
      if (cmd_ready !== 1'b1 || in_ready !== 1'b0 || done !== 1'b0) begin
         errors++;
         $display("FAIL midfill_release cmd_ready=%0b in_ready=%0b done=%0b expected 1 0 0",
                  cmd_ready, in_ready, done);
      end
      run_fill(0, 8, 0, 1'b0);
   endtask

   task automatic test_random();
      for (int t = 0; t < 8; t++)
         run_fill($urandom_range(0, N - 1), $urandom_range(0, 50), $urandom_range(0, 2), 1'b0);
   endtask

   task automatic test_back_to_back();
      run_fill(3000, 24, 0, 1'b0);
      run_fill(3024, 17, 0, 1'b0);
   endtask

   initial begin
      for (int i = 0; i < N; i++) exp_mem[i] = 8'(i*37 + 5);
      test_reset();
      test_full_fill();
      test_partial();
      test_wrap();
      test_backpressure();
      test_len_zero();
      test_reset_mid_fill();
      test_random();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
